// File: rtl/bridge_pkg.sv
// Shared types and AXI constants for the SRAM-like to AXI4 bridge.
package bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR      = 3'd3,
    ST_WR_RESP = 3'd4
  } state_t;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/sramlike_arbiter.sv
// Fixed-priority grant between the instruction and data SRAM-like ports.
module sramlike_arbiter #(
  parameter logic DATA_PRIORITY = 1'b1
) (
  input  logic [3:0] inst_cen,
  input  logic [3:0] data_cen,
  output logic       grant,
  output logic       owner
);

  logic inst_req_s;
  logic data_req_s;

  assign inst_req_s = |inst_cen;
  assign data_req_s = |data_cen;
  assign grant      = inst_req_s | data_req_s;

  // owner: 1 selects the data port, 0 the instruction port
  always_comb begin
    owner = 1'b0;
    if (inst_req_s && data_req_s) begin
      owner = DATA_PRIORITY;
    end else if (data_req_s) begin
      owner = 1'b1;
    end else begin
      owner = 1'b0;
    end
  end

endmodule

// File: rtl/sramlike_axi_bridge.sv
// Bridges the core's instruction and data SRAM-like ports onto one
// single-beat AXI4 master, one transaction outstanding at a time.
module sramlike_axi_bridge
  import bridge_pkg::*;
#(
  parameter logic       DATA_PRIORITY = 1'b1,
  parameter logic [3:0] AXI_ID        = 4'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  inst_sram_cen,
  input  logic        inst_sram_wr,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_ack,
  output logic        inst_sram_rrdy,
  output logic [31:0] inst_sram_rdata,
  input  logic [3:0]  data_sram_cen,
  input  logic        data_sram_wr,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_ack,
  output logic        data_sram_rrdy,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  m_axi_awid,
  output logic [31:0] m_axi_awaddr,
  output logic [7:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic [1:0]  m_axi_awburst,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wlast,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  input  logic [1:0]  m_axi_bresp,
  output logic [3:0]  m_axi_arid,
  output logic [31:0] m_axi_araddr,
  output logic [7:0]  m_axi_arlen,
  output logic [2:0]  m_axi_arsize,
  output logic [1:0]  m_axi_arburst,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rlast,
  output logic        bus_err
);

  state_t      state_r, state_s;
  logic        owner_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [3:0]  wstrb_r;
  logic        aw_done_r;
  logic        w_done_r;
  logic        bus_err_r;
  logic [31:0] inst_rdata_r;
  logic [31:0] data_rdata_r;

  logic        grant_s;
  logic        owner_s;
  logic        req_wr_s;
  logic [31:0] req_addr_s;
  logic [31:0] req_wdata_s;
  logic [3:0]  req_cen_s;
  logic        aw_hs_s;
  logic        w_hs_s;
  logic        rd_done_s;
  logic        wr_done_s;
  logic        unused_rlast_s;

  assign unused_rlast_s = m_axi_rlast;

  sramlike_arbiter #(
    .DATA_PRIORITY (DATA_PRIORITY)
  ) u_arbiter (
    .inst_cen (inst_sram_cen),
    .data_cen (data_sram_cen),
    .grant    (grant_s),
    .owner    (owner_s)
  );

  // Request fields of whichever port the arbiter picked
  always_comb begin
    req_wr_s    = 1'b0;
    req_addr_s  = 32'd0;
    req_wdata_s = 32'd0;
    req_cen_s   = 4'd0;
    if (owner_s) begin
      req_wr_s    = data_sram_wr;
      req_addr_s  = data_sram_addr;
      req_wdata_s = data_sram_wdata;
      req_cen_s   = data_sram_cen;
    end else begin
      req_wr_s    = inst_sram_wr;
      req_addr_s  = inst_sram_addr;
      req_wdata_s = inst_sram_wdata;
      req_cen_s   = inst_sram_cen;
    end
  end

  assign m_axi_arvalid = (state_r == ST_RD_ADDR);
  assign m_axi_rready  = (state_r == ST_RD_DATA);
  assign m_axi_awvalid = (state_r == ST_WR) && !aw_done_r;
  assign m_axi_wvalid  = (state_r == ST_WR) && !w_done_r;
  assign m_axi_wlast   = m_axi_wvalid;
  assign m_axi_bready  = (state_r == ST_WR_RESP);

  assign aw_hs_s   = m_axi_awvalid && m_axi_awready;
  assign w_hs_s    = m_axi_wvalid && m_axi_wready;
  assign rd_done_s = m_axi_rready && m_axi_rvalid;
  assign wr_done_s = m_axi_bready && m_axi_bvalid;

  assign m_axi_awid    = AXI_ID;
  assign m_axi_arid    = AXI_ID;
  assign m_axi_awaddr  = addr_r;
  assign m_axi_araddr  = addr_r;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_awsize  = AXI_SIZE_4B;
  assign m_axi_arsize  = AXI_SIZE_4B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_wdata   = wdata_r;
  assign m_axi_wstrb   = wstrb_r;
  assign bus_err       = bus_err_r;

  // Next-state logic for the single-outstanding transaction FSM
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_s = req_wr_s ? ST_WR : ST_RD_ADDR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (m_axi_arready) begin
          state_s = ST_RD_DATA;
        end else begin
          state_s = ST_RD_ADDR;
        end
      end
      ST_RD_DATA: begin
        if (m_axi_rvalid) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RD_DATA;
        end
      end
      ST_WR: begin
        if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
          state_s = ST_WR_RESP;
        end else begin
          state_s = ST_WR;
        end
      end
      ST_WR_RESP: begin
        if (m_axi_bvalid) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WR_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request latch on grant and per-channel write progress
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_r   <= 1'b0;
      addr_r    <= 32'd0;
      wdata_r   <= 32'd0;
      wstrb_r   <= 4'd0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else if (state_r == ST_IDLE && grant_s) begin
      owner_r   <= owner_s;
      addr_r    <= req_addr_s;
      wdata_r   <= req_wdata_s;
      wstrb_r   <= req_cen_s;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else if (state_r == ST_WR) begin
      aw_done_r <= aw_done_r | aw_hs_s;
      w_done_r  <= w_done_r | w_hs_s;
    end
  end

  // Sticky error flag and last-read data held per port
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus_err_r    <= 1'b0;
      inst_rdata_r <= 32'd0;
      data_rdata_r <= 32'd0;
    end else begin
      if ((rd_done_s && m_axi_rresp != AXI_RESP_OKAY) ||
          (wr_done_s && m_axi_bresp != AXI_RESP_OKAY)) begin
        bus_err_r <= 1'b1;
      end
      if (rd_done_s && !owner_r) begin
        inst_rdata_r <= m_axi_rdata;
      end
      if (rd_done_s && owner_r) begin
        data_rdata_r <= m_axi_rdata;
      end
    end
  end

  // Port-side handshakes; rdata passes the beat through in its rrdy cycle
  always_comb begin
    inst_sram_ack   = (state_r == ST_IDLE) && grant_s && !owner_s && !reset;
    data_sram_ack   = (state_r == ST_IDLE) && grant_s && owner_s && !reset;
    inst_sram_rrdy  = (rd_done_s || wr_done_s) && !owner_r;
    data_sram_rrdy  = (rd_done_s || wr_done_s) && owner_r;
    inst_sram_rdata = inst_rdata_r;
    data_sram_rdata = data_rdata_r;
    if (rd_done_s && !owner_r) begin
      inst_sram_rdata = m_axi_rdata;
    end else begin
      inst_sram_rdata = inst_rdata_r;
    end
    if (rd_done_s && owner_r) begin
      data_sram_rdata = m_axi_rdata;
    end else begin
      data_sram_rdata = data_rdata_r;
    end
  end

endmodule

// File: tb/tb_sramlike_axi_bridge.sv
// Directed bench for sramlike_axi_bridge: the bench plays the AXI slave
// cycle by cycle and checks port and bus behaviour against hand-derived values.
module tb_sramlike_axi_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  inst_sram_cen, data_sram_cen;
  logic        inst_sram_wr, data_sram_wr;
  logic [31:0] inst_sram_addr, inst_sram_wdata, data_sram_addr, data_sram_wdata;
  logic        inst_sram_ack, inst_sram_rrdy, data_sram_ack, data_sram_rrdy;
  logic [31:0] inst_sram_rdata, data_sram_rdata;
  logic [3:0]  m_axi_awid, m_axi_arid, m_axi_wstrb;
  logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
  logic [7:0]  m_axi_awlen, m_axi_arlen;
  logic [2:0]  m_axi_awsize, m_axi_arsize;
  logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready, m_axi_rlast, bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sramlike_axi_bridge #(.DATA_PRIORITY(1'b1), .AXI_ID(4'd0)) dut (
    .clock(clock), .reset(reset),
    .inst_sram_cen(inst_sram_cen), .inst_sram_wr(inst_sram_wr),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_ack(inst_sram_ack), .inst_sram_rrdy(inst_sram_rrdy),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_cen(data_sram_cen), .data_sram_wr(data_sram_wr),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_ack(data_sram_ack), .data_sram_rrdy(data_sram_rrdy),
    .data_sram_rdata(data_sram_rdata),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic samp();
    @(negedge clock);
  endtask

  int aw_cnt, w_cnt, rrdy_cnt, rrdy_cyc, inst_rrdy_cnt;
  logic stable;

  initial begin
    reset = 1'b1;
    inst_sram_cen = 4'hf; inst_sram_wr = 1'b0; inst_sram_addr = 32'h0; inst_sram_wdata = 32'h0;
    data_sram_cen = 4'h0; data_sram_wr = 1'b0; data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = 32'h0; m_axi_rresp = 2'b00;
    m_axi_rlast = 1'b1;

    // reset state, with a request already pending
    samp();
    check("rst_inst_ack", 32'(inst_sram_ack), 32'd0);
    check("rst_arvalid", 32'(m_axi_arvalid), 32'd0);
    check("rst_awvalid", 32'(m_axi_awvalid), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_araddr", m_axi_araddr, 32'h0);
    check("rst_inst_rdata", inst_sram_rdata, 32'h0);
    tick(); reset = 1'b0; inst_sram_cen = 4'h0;

    // single instruction read, zero-wait slave
    tick(); inst_sram_cen = 4'hf; inst_sram_addr = 32'h1fc00000;
    samp();
    check("rd_inst_ack", 32'(inst_sram_ack), 32'd1);
    check("rd_data_ack", 32'(data_sram_ack), 32'd0);
    tick(); inst_sram_cen = 4'h0; m_axi_arready = 1'b1;
    samp();
    check("rd_arvalid", 32'(m_axi_arvalid), 32'd1);
    check("rd_araddr", m_axi_araddr, 32'h1fc00000);
    check("rd_arsize", 32'(m_axi_arsize), 32'd2);
    tick(); m_axi_arready = 1'b0; m_axi_rvalid = 1'b1; m_axi_rdata = 32'hdeadbeef;
    samp();
    check("rd_rrdy", 32'(inst_sram_rrdy), 32'd1);
    check("rd_rdata", inst_sram_rdata, 32'hdeadbeef);
    check("rd_bus_err", 32'(bus_err), 32'd0);
    tick(); m_axi_rvalid = 1'b0;
    samp();
    check("rd_rrdy_pulse", 32'(inst_sram_rrdy), 32'd0);

    // byte write with awready 3 cycles late and wready 1 cycle late
    tick(); data_sram_cen = 4'b0100; data_sram_wr = 1'b1;
    data_sram_addr = 32'h80000002; data_sram_wdata = 32'h00ab0000;
    samp();
    check("wr_data_ack", 32'(data_sram_ack), 32'd1);
    aw_cnt = 0; w_cnt = 0; rrdy_cnt = 0; rrdy_cyc = 0; inst_rrdy_cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      data_sram_cen = 4'h0;
      m_axi_awready = (c == 4); m_axi_wready = (c == 2); m_axi_bvalid = (c == 6);
      samp();
      if (m_axi_awvalid && m_axi_awready) aw_cnt++;
      if (m_axi_wvalid && m_axi_wready) w_cnt++;
      if (data_sram_rrdy) begin rrdy_cnt++; rrdy_cyc = c; end
      if (inst_sram_rrdy) inst_rrdy_cnt++;
      if (c == 1) begin
        check("wr_wstrb", 32'(m_axi_wstrb), 32'h4);
        check("wr_wdata", m_axi_wdata, 32'h00ab0000);
        check("wr_awaddr", m_axi_awaddr, 32'h80000002);
        check("wr_wlast", 32'(m_axi_wlast), 32'd1);
      end
      if (c == 3) begin
        check("wr_aw_held", 32'(m_axi_awvalid), 32'd1);
        check("wr_w_dropped", 32'(m_axi_wvalid), 32'd0);
      end
      if (c == 5) check("wr_bready", 32'(m_axi_bready), 32'd1);
    end
    check("wr_aw_count", 32'(aw_cnt), 32'd1);
    check("wr_w_count", 32'(w_cnt), 32'd1);
    check("wr_rrdy_count", 32'(rrdy_cnt), 32'd1);
    check("wr_rrdy_cycle", 32'(rrdy_cyc), 32'd6);
    check("wr_inst_rrdy", 32'(inst_rrdy_cnt), 32'd0);
    check("wr_keeps_rdata", data_sram_rdata, 32'h0);

    // simultaneous requests: data wins, inst served afterwards with error resp
    tick(); m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
    inst_sram_cen = 4'hf; inst_sram_wr = 1'b0; inst_sram_addr = 32'h100;
    data_sram_cen = 4'hf; data_sram_wr = 1'b0; data_sram_addr = 32'h200;
    samp();
    check("sim_data_ack", 32'(data_sram_ack), 32'd1);
    check("sim_inst_ack", 32'(inst_sram_ack), 32'd0);
    tick(); data_sram_cen = 4'h0; m_axi_arready = 1'b1;
    samp();
    check("sim_araddr", m_axi_araddr, 32'h200);
    check("sim_inst_wait1", 32'(inst_sram_ack), 32'd0);
    tick(); m_axi_arready = 1'b0; m_axi_rvalid = 1'b1; m_axi_rdata = 32'h22222222;
    samp();
    check("sim_data_rrdy", 32'(data_sram_rrdy), 32'd1);
    check("sim_data_rdata", data_sram_rdata, 32'h22222222);
    check("sim_inst_wait2", 32'(inst_sram_ack), 32'd0);
    tick(); m_axi_rvalid = 1'b0;
    samp();
    check("sim_inst_ack_late", 32'(inst_sram_ack), 32'd1);
    tick(); inst_sram_cen = 4'h0; m_axi_arready = 1'b1;
    samp();
    check("sim_inst_araddr", m_axi_araddr, 32'h100);
    tick(); m_axi_arready = 1'b0; m_axi_rvalid = 1'b1; m_axi_rdata = 32'h33333333;
    m_axi_rresp = 2'b10;
    samp();
    check("err_rrdy", 32'(inst_sram_rrdy), 32'd1);
    check("err_rdata", inst_sram_rdata, 32'h33333333);
    tick(); m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00;
    samp();
    check("err_bus_err", 32'(bus_err), 32'd1);

    // arready backpressure for 10 cycles with data port waiting
    tick(); inst_sram_cen = 4'hf; inst_sram_addr = 32'h300;
    samp();
    check("bp_inst_ack", 32'(inst_sram_ack), 32'd1);
    tick(); inst_sram_cen = 4'h0;
    data_sram_cen = 4'hf; data_sram_wr = 1'b0; data_sram_addr = 32'h400;
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      samp();
      if (!m_axi_arvalid || m_axi_araddr !== 32'h300 || data_sram_ack || inst_sram_ack)
        stable = 1'b0;
      tick();
    end
    check("bp_stable", 32'(stable), 32'd1);
    m_axi_arready = 1'b1;
    samp();
    check("bp_arvalid_end", 32'(m_axi_arvalid), 32'd1);
    tick(); m_axi_arready = 1'b0; m_axi_rvalid = 1'b1; m_axi_rdata = 32'h44444444;
    samp();
    check("bp_rrdy", 32'(inst_sram_rrdy), 32'd1);
    check("bp_rdata", inst_sram_rdata, 32'h44444444);
    check("bp_no_data_ack", 32'(data_sram_ack), 32'd0);
    tick(); m_axi_rvalid = 1'b0;
    samp();
    check("bp_data_ack", 32'(data_sram_ack), 32'd1);
    check("sticky_after_okay", 32'(bus_err), 32'd1);
    tick(); data_sram_cen = 4'h0; m_axi_arready = 1'b1;
    samp();
    check("bp_data_araddr", m_axi_araddr, 32'h400);
    tick(); m_axi_arready = 1'b0; m_axi_rvalid = 1'b1; m_axi_rdata = 32'h55555555;
    samp();
    check("bp_data_rdata", data_sram_rdata, 32'h55555555);
    tick(); m_axi_rvalid = 1'b0;
    samp();
    check("sticky_after_two", 32'(bus_err), 32'd1);

    // reset while waiting for the write response
    tick(); data_sram_cen = 4'hf; data_sram_wr = 1'b1;
    data_sram_addr = 32'h500; data_sram_wdata = 32'h12345678;
    samp();
    check("mr_ack", 32'(data_sram_ack), 32'd1);
    tick(); data_sram_cen = 4'h0; m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    samp();
    check("mr_both_valid", 32'({m_axi_awvalid, m_axi_wvalid}), 32'd3);
    tick(); m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    samp();
    check("mr_bready", 32'(m_axi_bready), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mr_bready_async", 32'(m_axi_bready), 32'd0);
    check("mr_bus_err_async", 32'(bus_err), 32'd0);
    check("mr_awaddr_async", m_axi_awaddr, 32'h0);
    check("mr_rdata_async", inst_sram_rdata, 32'h0);
    tick(); m_axi_bvalid = 1'b1;
    samp();
    check("mr_no_rrdy", 32'(data_sram_rrdy), 32'd0);
    tick(); reset = 1'b0; m_axi_bvalid = 1'b0;
    tick(); inst_sram_cen = 4'hf; inst_sram_wr = 1'b0; inst_sram_addr = 32'h600;
    samp();
    check("post_ack", 32'(inst_sram_ack), 32'd1);
    tick(); inst_sram_cen = 4'h0; m_axi_arready = 1'b1;
    samp();
    check("post_araddr", m_axi_araddr, 32'h600);
    tick(); m_axi_arready = 1'b0; m_axi_rvalid = 1'b1; m_axi_rdata = 32'hcafef00d;
    samp();
    check("post_rrdy", 32'(inst_sram_rrdy), 32'd1);
    check("post_rdata", inst_sram_rdata, 32'hcafef00d);
    check("post_bus_err", 32'(bus_err), 32'd0);
    tick(); m_axi_rvalid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
